// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame receive controller: FSM encoding,
// error codes, default sync byte and a saturating increment helper.
package uart_frame_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT    = 2'd0;
    localparam state_t ST_TYPE    = 2'd1;
    localparam state_t ST_PAYLOAD = 2'd2;
    localparam state_t ST_CHECK   = 2'd3;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'd0;
    localparam err_code_t ERR_CHK     = 2'd1;
    localparam err_code_t ERR_TIMEOUT = 2'd2;
    localparam err_code_t ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_rx_ctrl_if.sv
// Byte-strobe input, frame handshake and error status of the frame receiver.
// master = byte receiver / game logic side, slave = uart_frame_rx_ctrl.
interface uart_frame_rx_ctrl_if
    import uart_frame_pkg::*;
#(
    parameter int PAYLOAD_LEN = 4
);
    logic                     rx_done_tick;
    logic [7:0]               rx_byte;
    logic                     frame_ack;
    logic                     frame_pending;
    logic [7:0]               frame_type;
    logic [PAYLOAD_LEN*8-1:0] frame_payload;
    logic                     err_tick;
    err_code_t                err_code;
    logic [7:0]               err_count;

    modport master (
        output rx_done_tick, rx_byte, frame_ack,
        input  frame_pending, frame_type, frame_payload, err_tick, err_code, err_count
    );

    modport slave (
        input  rx_done_tick, rx_byte, frame_ack,
        output frame_pending, frame_type, frame_payload, err_tick, err_code, err_count
    );
endinterface

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter: counts idle cycles while enabled, clears on a byte,
// and pulses expired when TIMEOUT_CYCLES-1 is reached without a byte.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (cnt_q == TC) begin
            expired = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_frame_rx_ctrl.sv
// Frame-level receive controller: sync hunt, packet assembly, pending/ack hand-off,
// timeout/overrun errors. Define UART_FRAME_CHECKSUM_EN to add the trailing XOR byte.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_HUNT    | discard bytes until SYNC_BYTE
// ST_TYPE    | next byte is the frame type
// ST_PAYLOAD | collect PAYLOAD_LEN payload bytes
// ST_CHECK   | compare received checksum (checksum build only)
module uart_frame_rx_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         PAYLOAD_LEN    = 4,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_rx_ctrl_if.slave  bus
);
    localparam int IDX_W = 4;
    localparam int PL_W  = PAYLOAD_LEN * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       type_sh_q, type_sh_d;
    logic [PL_W-1:0]  shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [7:0]       ftype_q, ftype_d;
    logic [PL_W-1:0]  fpay_q, fpay_d;
    logic             etick_q, etick_d;
    err_code_t        ecode_q, ecode_d;
    logic [7:0]       ecnt_q, ecnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic      expired;
    logic      complete;
    logic      err_raise;
    err_code_t err_sel;

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != ST_HUNT),
        .clear   (bus.rx_done_tick),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        type_sh_d = type_sh_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q & ~bus.frame_ack;
        ftype_d   = ftype_q;
        fpay_d    = fpay_q;
        etick_d   = 1'b0;
        ecode_d   = ecode_q;
        ecnt_d    = ecnt_q;
`ifdef UART_FRAME_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        complete  = 1'b0;
        err_raise = 1'b0;
        err_sel   = ERR_NONE;

        // expired is never asserted in a byte cycle, so a late byte always wins
        if (expired) begin
            err_raise = 1'b1;
            err_sel   = ERR_TIMEOUT;
            state_d   = ST_HUNT;
            idx_d     = '0;
        end else if (bus.rx_done_tick) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.rx_byte == SYNC_BYTE) state_d = ST_TYPE;
                end
                ST_TYPE: begin
                    type_sh_d = bus.rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
                    chk_d     = bus.rx_byte;
`endif
                    idx_d     = '0;
                    state_d   = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    shadow_d[int'(idx_q)*8 +: 8] = bus.rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
                    chk_d = chk_q ^ bus.rx_byte;
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        complete = 1'b1;
                        state_d  = ST_HUNT;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (bus.rx_byte == chk_q) begin
                        complete = 1'b1;
                    end else begin
                        err_raise = 1'b1;
                        err_sel   = ERR_CHK;
                    end
                    state_d = ST_HUNT;
                end
`endif
                default: state_d = ST_HUNT;
            endcase
        end

        if (complete) begin
            if (!pend_q || bus.frame_ack) begin
                pend_d  = 1'b1;
                ftype_d = type_sh_q;
                fpay_d  = shadow_d;
            end else begin
                err_raise = 1'b1;
                err_sel   = ERR_OVERRUN;
            end
        end

        if (err_raise) begin
            etick_d = 1'b1;
            ecode_d = err_sel;
            ecnt_d  = sat_inc8(ecnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            idx_q     <= '0;
            type_sh_q <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            ftype_q   <= '0;
            fpay_q    <= '0;
            etick_q   <= 1'b0;
            ecode_q   <= ERR_NONE;
            ecnt_q    <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            type_sh_q <= type_sh_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            ftype_q   <= ftype_d;
            fpay_q    <= fpay_d;
            etick_q   <= etick_d;
            ecode_q   <= ecode_d;
            ecnt_q    <= ecnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign bus.frame_pending = pend_q;
    assign bus.frame_type    = ftype_q;
    assign bus.frame_payload = fpay_q;
    assign bus.err_tick      = etick_q;
    assign bus.err_code      = ecode_q;
    assign bus.err_count     = ecnt_q;

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Directed bench for uart_frame_rx_ctrl (PAYLOAD_LEN=4, TIMEOUT_CYCLES=50);
// follows UART_FRAME_CHECKSUM_EN to decide whether a CHK byte is sent.
module tb_uart_frame_rx_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 50;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_frame_rx_ctrl_if #(.PAYLOAD_LEN(4)) bus ();

    uart_frame_rx_ctrl #(
        .SYNC_BYTE      (SYNC),
        .PAYLOAD_LEN    (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pre_ack;
        logic        noise;
        logic [7:0]  ftype;
        logic [31:0] pl;
        logic        bad_chk;
        logic        ack_last;
        logic        exp_pend;
        logic [7:0]  exp_type;
        logic [31:0] exp_pl;
        logic        exp_tick;
        logic [1:0]  exp_code;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        bus.rx_done_tick = 1'b1;
        bus.rx_byte      = b;
        bus.frame_ack    = ack;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.frame_ack    = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends SYNC, type, payload (and CHK in the checksum build); returns 1 ns after the last edge.
    task automatic send_frame(input logic [7:0] t, input logic [31:0] pl,
                              input logic bad_chk, input logic ack_last);
        logic [7:0] chk;
        chk = t;
        send_byte(SYNC, 1'b0);
        send_byte(t, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk ^= pl[i*8 +: 8];
`ifdef UART_FRAME_CHECKSUM_EN
            send_byte(pl[i*8 +: 8], 1'b0);
`else
            send_byte(pl[i*8 +: 8], (i == 3) ? ack_last : 1'b0);
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(chk ^ {7'd0, bad_chk}, ack_last);
`else
        if (bad_chk) $display("note: bad_chk ignored without checksum");
`endif
    endtask

    task automatic check_frame(input string tag, input logic p, input logic [7:0] t,
                               input logic [31:0] pl, input logic tk, input logic [1:0] c,
                               input logic [7:0] n);
        check({tag, ".pending"}, {31'd0, bus.frame_pending}, {31'd0, p});
        check({tag, ".type"},    {24'd0, bus.frame_type},    {24'd0, t});
        check({tag, ".payload"}, bus.frame_payload,          pl);
        check({tag, ".err_tick"},{31'd0, bus.err_tick},      {31'd0, tk});
        check({tag, ".err_code"},{30'd0, bus.err_code},      {30'd0, c});
        check({tag, ".err_cnt"}, {24'd0, bus.err_count},     {24'd0, n});
    endtask

    logic [7:0] exp_cnt;
    int         early;

    initial begin
        //               pre noi type    payload       bad ack  pend type    payload       tk code cnt
        vecs.push_back('{1'b0,1'b1,8'h07,32'h44332211,1'b0,1'b0, 1'b1,8'h07,32'h44332211,1'b0,2'd0,8'd0});
        vecs.push_back('{1'b1,1'b0,8'h3C,32'hFF00A5A5,1'b0,1'b0, 1'b1,8'h3C,32'hFF00A5A5,1'b0,2'd0,8'd0});
        vecs.push_back('{1'b0,1'b0,8'h01,32'h04030201,1'b0,1'b0, 1'b1,8'h3C,32'hFF00A5A5,1'b1,2'd3,8'd1});
        vecs.push_back('{1'b0,1'b0,8'h02,32'h0D0C0B0A,1'b0,1'b1, 1'b1,8'h02,32'h0D0C0B0A,1'b0,2'd3,8'd1});
`ifdef UART_FRAME_CHECKSUM_EN
        vecs.push_back('{1'b1,1'b0,8'h07,32'h44332211,1'b1,1'b0, 1'b0,8'h02,32'h0D0C0B0A,1'b1,2'd1,8'd2});
`endif

        bus.rx_done_tick = 1'b0;
        bus.rx_byte      = 8'h00;
        bus.frame_ack    = 1'b0;
        reset            = 1'b1;
        idle(3);
        check_frame("reset", 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;
        idle(1);

        pulse_ack();
        check("ack_no_pending", {31'd0, bus.frame_pending}, 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].pre_ack) pulse_ack();
            if (vecs[k].noise) begin
                send_byte(8'h00, 1'b0);
                send_byte(8'hFF, 1'b0);
                send_byte(8'h5A, 1'b0);
            end
            send_frame(vecs[k].ftype, vecs[k].pl, vecs[k].bad_chk, vecs[k].ack_last);
            check_frame($sformatf("vec%0d", k), vecs[k].exp_pend, vecs[k].exp_type,
                        vecs[k].exp_pl, vecs[k].exp_tick, vecs[k].exp_code, vecs[k].exp_cnt);
            idle(1);
        end
        exp_cnt = vecs[vecs.size()-1].exp_cnt;

        // Timeout: error becomes visible exactly TO edges after the last byte edge
        pulse_ack();
        send_byte(SYNC, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h11, 1'b0);
        early = 0;
        for (int i = 1; i < TO; i++) begin
            idle(1);
            if (bus.err_tick) early++;
        end
        check("timeout_early", early, 0);
        idle(1);
        exp_cnt++;
        check("timeout_tick", {31'd0, bus.err_tick}, 32'd1);
        check("timeout_code", {30'd0, bus.err_code}, 32'd2);
        check("timeout_cnt",  {24'd0, bus.err_count}, {24'd0, exp_cnt});
        idle(1);
        check("timeout_tick_1cyc", {31'd0, bus.err_tick}, 32'd0);
        send_frame(8'h07, 32'h44332211, 1'b0, 1'b0);
        check_frame("after_timeout", 1'b1, 8'h07, 32'h44332211, 1'b0, 2'd2, exp_cnt);

        // Byte arriving in the very cycle the timeout would fire wins
        pulse_ack();
        send_byte(SYNC, 1'b0);
        send_byte(8'h09, 1'b0);
        idle(TO - 1);
        send_byte(8'h55, 1'b0);
        check("late_byte_no_tick", {31'd0, bus.err_tick}, 32'd0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(8'h09 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 1'b0);
`endif
        check_frame("late_byte", 1'b1, 8'h09, 32'h88776655, 1'b0, 2'd2, exp_cnt);

        // Reset after the third payload byte
        send_byte(SYNC, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        reset = 1'b1;
        #2;
        check_frame("reset_mid", 1'b0, 8'h00, 32'h0, 1'b0, 2'd0, 8'd0);
        idle(1);
        reset = 1'b0;
        idle(1);
        check("reset_mid_held_tick", {31'd0, bus.err_tick}, 32'd0);
        send_frame(8'h07, 32'h44332211, 1'b0, 1'b0);
        check_frame("after_reset", 1'b1, 8'h07, 32'h44332211, 1'b0, 2'd0, 8'd0);

        // Overrun storm: error counter must saturate at 255
        for (int i = 0; i < 256; i++) send_frame(8'hEE, i, 1'b0, 1'b0);
        check_frame("saturate", 1'b1, 8'h07, 32'h44332211, 1'b1, 2'd3, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
